// File: rtl/mm_tile_pkg.sv
// Shared state type, default parameters and the saturating-add helper for mm_tile_core.
// sat_add is referenced only when MM_TILE_SATURATE_EN is defined.
package mm_tile_pkg;

   localparam int TILE_DEF   = 2;
   localparam int ELEM_W_DEF = 8;
   localparam int ACC_W_DEF  = 32;
   localparam int SIZE_W_DEF = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } mm_state_t;

   // Exact sum of two sign-extended operands, clamped to the signed range of a w-bit word (w <= 63).
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                  input logic signed [63:0] y,
                                                  input int w);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sum = x + y;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w - 1));
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/mm_tile_mac.sv
// One accumulator cell: signed multiply, sign-extend, accumulate with overflow flag.
// Wraps by default; clamps to the signed ACC_W range when MM_TILE_SATURATE_EN is defined.
module mm_tile_mac
   import mm_tile_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [ELEM_W-1:0] a,
   input  logic signed [ELEM_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc,
   output logic                     ovf
);

   logic signed [2*ELEM_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    sum_wrap;
   logic signed [ACC_W-1:0]    acc_next;
   logic                       ovf_raw;

   // Overflow is only possible when both addends share a sign and the wrapped sum does not.
   always_comb begin
      prod     = a * b;
      prod_ext = ACC_W'(prod);
      sum_wrap = acc + prod_ext;
      ovf_raw  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
`ifdef MM_TILE_SATURATE_EN
      acc_next = ACC_W'(sat_add(64'(acc), 64'(prod_ext), ACC_W));
`else
      acc_next = sum_wrap;
`endif
   end

   assign ovf = en & ovf_raw;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/mm_tile_core.sv
// TILE x TILE outer-product matrix multiply core with row-by-row handshaked drain.
// Define MM_TILE_SATURATE_EN to make every accumulator saturate instead of wrap.
module mm_tile_core
   import mm_tile_pkg::*;
#(
   parameter int TILE   = TILE_DEF,
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int SIZE_W = SIZE_W_DEF
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic [SIZE_W-1:0]                        size,
   input  logic [TILE*ELEM_W-1:0]                   inA,
   input  logic [TILE*ELEM_W-1:0]                   inB,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [((TILE > 1) ? $clog2(TILE) : 1)-1:0] out_row,
   output logic [TILE*ACC_W-1:0]                    C_row,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     ovf
);

   localparam int ROW_W = (TILE > 1) ? $clog2(TILE) : 1;

   if (ACC_W < 2*ELEM_W || ACC_W > 63) begin : g_bad_acc_w
      $error("mm_tile_core: ACC_W must be at least 2*ELEM_W and at most 63");
   end

   mm_state_t                               state;
   logic [SIZE_W-1:0]                       size_q;
   logic [SIZE_W-1:0]                       beat_cnt;
   logic                                    beat;
   logic                                    acc_clear;
   logic [TILE-1:0][TILE-1:0][ACC_W-1:0]    acc_arr;
   logic [TILE*TILE-1:0]                    mac_ovf;

   assign beat      = (state == ACCUM) && in_valid;
   assign acc_clear = (state == IDLE) && start;
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign C_row     = out_valid ? acc_arr[out_row] : '0;

   for (genvar i = 0; i < TILE; i++) begin : g_row
      for (genvar j = 0; j < TILE; j++) begin : g_col
         mm_tile_mac #(
            .ELEM_W (ELEM_W),
            .ACC_W  (ACC_W)
         ) u_mac (
            .clk   (clk),
            .reset (reset),
            .clear (acc_clear),
            .en    (beat),
            .a     (inA[i*ELEM_W +: ELEM_W]),
            .b     (inB[j*ELEM_W +: ELEM_W]),
            .acc   (acc_arr[i][j]),
            .ovf   (mac_ovf[i*TILE + j])
         );
      end
   end

   // The last beat of a job and the last row handshake both change state on their own edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         size_q   <= '0;
         beat_cnt <= '0;
         out_row  <= '0;
         done     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  size_q   <= size;
                  beat_cnt <= '0;
                  out_row  <= '0;
                  ovf      <= 1'b0;
                  state    <= (size == '0) ? DRAIN : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (|mac_ovf) begin
                     ovf <= 1'b1;
                  end
                  if ((beat_cnt + 1'b1) == size_q) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_row == ROW_W'(TILE - 1)) begin
                     out_row <= '0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     out_row <= out_row + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
